// File: rtl/downsample_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : downsample_scan_gen
// Purpose  : Blanking-interval scan generator for the gesture downsampling
//            path. Forwards raster coordinates during active drawing. In
//            vertical blanking it replays the camera frame as vertical
//            strips, WIN_H taps per column, with a valid/ready handshake.
// Ports    : clk_in, rst_in      - clock, synchronous active-high reset
//            hcount_in/vcount_in - raster position
//            ready_in            - downstream accepts the current beat
//            valid_draw_out      - raster is inside the camera window (comb.)
//            hcount_ds_out/vcount_ds_out/tap_out - registered coordinate
//            valid_ds_out        - a scan beat is presented
//            col_last_out/row_last_out - last tap of column / last of strip
//            frame_done_out/overrun_out - completion / abort pulses
//            busy_out            - scan in progress
//            overrun_count_out   - saturating abort count
// Options  : DS_SCAN_OVERRUN_CNT_EN builds the overrun counter; without it
//            overrun_count_out is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module downsample_scan_gen #(
    parameter int TOTAL_PIXELS = 1650,
    parameter int TOTAL_LINES  = 750,
    parameter int CAM_WIDTH    = 240,
    parameter int CAM_HEIGHT   = 320,
    parameter int WIN_H        = 5,
    parameter int TRIGGER_LINE = TOTAL_LINES
                                 - (CAM_WIDTH * CAM_HEIGHT + TOTAL_PIXELS - 1) / TOTAL_PIXELS
                                 - 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [10:0]               hcount_in,
    input  logic [9:0]                vcount_in,
    input  logic                      ready_in,
    output logic                      valid_draw_out,
    output logic [10:0]               hcount_ds_out,
    output logic [9:0]                vcount_ds_out,
    output logic [$clog2(WIN_H)-1:0]  tap_out,
    output logic                      valid_ds_out,
    output logic                      col_last_out,
    output logic                      row_last_out,
    output logic                      frame_done_out,
    output logic                      overrun_out,
    output logic                      busy_out,
    output logic [7:0]                overrun_count_out
);

    localparam int TAP_W = $clog2(WIN_H);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [10:0]        hcount_q, hcount_d;
    logic [9:0]         vcount_q, vcount_d;
    logic [9:0]         base_q, base_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               col_last_q, col_last_d;
    logic               row_last_q, row_last_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;

    logic               w_trigger;
    logic               w_abort;
    logic               w_consume;
    logic               w_last_beat;
    logic [TAP_W-1:0]   w_tap_nx;
    logic [10:0]        w_h_nx;
    logic [9:0]         w_base_nx;

    assign valid_draw_out = (hcount_in < 11'(CAM_WIDTH)) && (vcount_in < 10'(CAM_HEIGHT));

    assign w_trigger   = (vcount_in == 10'(TRIGGER_LINE)) && (hcount_in == 11'd0) && !valid_draw_out;
    assign w_abort     = (vcount_in == 10'd0) && (hcount_in == 11'd0);
    assign w_consume   = (state_q == S_SCAN) && ready_in;
    // row_last marks the final beat of a strip; the final strip has base H-WIN_H.
    assign w_last_beat = row_last_q && (base_q == 10'(CAM_HEIGHT - WIN_H));

    always_comb begin
        state_d    = state_q;
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        base_d     = base_q;
        tap_d      = tap_q;
        col_last_d = col_last_q;
        row_last_d = row_last_q;
        done_d     = 1'b0;
        overrun_d  = 1'b0;

        // Successor position in the vertical-strip raster.
        w_tap_nx  = tap_q + 1'b1;
        w_h_nx    = hcount_q;
        w_base_nx = base_q;
        if (tap_q == TAP_W'(WIN_H - 1)) begin
            w_tap_nx = '0;
            if (hcount_q == 11'(CAM_WIDTH - 1)) begin
                w_h_nx    = 11'd0;
                w_base_nx = base_q + 10'(WIN_H);
            end else begin
                w_h_nx = hcount_q + 11'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (w_trigger) begin
                    state_d    = S_SCAN;
                    hcount_d   = 11'd0;
                    vcount_d   = 10'd0;
                    base_d     = 10'd0;
                    tap_d      = '0;
                    col_last_d = 1'b0;
                    row_last_d = 1'b0;
                end else if (valid_draw_out) begin
                    hcount_d   = hcount_in;
                    vcount_d   = vcount_in;
                    tap_d      = '0;
                    col_last_d = 1'b0;
                    row_last_d = 1'b0;
                end
            end
            S_SCAN: begin
                // Completion outranks an abort landing on the same cycle.
                if (w_consume && w_last_beat) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    tap_d      = '0;
                    col_last_d = 1'b0;
                    row_last_d = 1'b0;
                end else if (w_abort) begin
                    state_d    = S_IDLE;
                    overrun_d  = 1'b1;
                    tap_d      = '0;
                    col_last_d = 1'b0;
                    row_last_d = 1'b0;
                end else if (w_consume) begin
                    hcount_d   = w_h_nx;
                    base_d     = w_base_nx;
                    tap_d      = w_tap_nx;
                    vcount_d   = w_base_nx + 10'(w_tap_nx);
                    col_last_d = (w_tap_nx == TAP_W'(WIN_H - 1));
                    row_last_d = (w_tap_nx == TAP_W'(WIN_H - 1)) && (w_h_nx == 11'(CAM_WIDTH - 1));
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            hcount_q   <= 11'd0;
            vcount_q   <= 10'd0;
            base_q     <= 10'd0;
            tap_q      <= '0;
            col_last_q <= 1'b0;
            row_last_q <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            base_q     <= base_d;
            tap_q      <= tap_d;
            col_last_q <= col_last_d;
            row_last_q <= row_last_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef DS_SCAN_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q;

    // Counts alongside the pulse so the new total is visible with it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ovr_cnt_q <= 8'd0;
        end else if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign overrun_count_out = ovr_cnt_q;
`else
    assign overrun_count_out = 8'd0;
`endif

    assign hcount_ds_out  = hcount_q;
    assign vcount_ds_out  = vcount_q;
    assign tap_out        = tap_q;
    assign valid_ds_out   = (state_q == S_SCAN);
    assign busy_out       = (state_q == S_SCAN);
    assign col_last_out   = col_last_q;
    assign row_last_out   = row_last_q;
    assign frame_done_out = done_q;
    assign overrun_out    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_downsample_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_downsample_scan_gen
// Purpose  : Directed self-checking bench for downsample_scan_gen: default
//            instance for full scan, backpressure, overrun, reset and draw
//            pass-through; small instance for a complete small-frame order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_downsample_scan_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] h;
    logic [9:0]  v;
    logic        rdy;
    logic        vd, vds_v, cl, rl, done, ovr, busy;
    logic [10:0] hds;
    logic [9:0]  vds;
    logic [2:0]  tap;
    logic [7:0]  cnt;

    logic [10:0] s_h;
    logic [9:0]  s_v;
    logic        s_rdy;
    logic        s_vd, s_valid, s_cl, s_rl, s_done, s_ovr, s_busy;
    logic [10:0] s_hds;
    logic [9:0]  s_vds;
    logic [1:0]  s_tap;
    logic [7:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    downsample_scan_gen u_dut (
        .clk_in(clk), .rst_in(rst), .hcount_in(h), .vcount_in(v), .ready_in(rdy),
        .valid_draw_out(vd), .hcount_ds_out(hds), .vcount_ds_out(vds), .tap_out(tap),
        .valid_ds_out(vds_v), .col_last_out(cl), .row_last_out(rl),
        .frame_done_out(done), .overrun_out(ovr), .busy_out(busy),
        .overrun_count_out(cnt)
    );

    downsample_scan_gen #(
        .TOTAL_PIXELS(20), .TOTAL_LINES(16), .CAM_WIDTH(4), .CAM_HEIGHT(6),
        .WIN_H(3), .TRIGGER_LINE(10)
    ) u_small (
        .clk_in(clk), .rst_in(rst), .hcount_in(s_h), .vcount_in(s_v), .ready_in(s_rdy),
        .valid_draw_out(s_vd), .hcount_ds_out(s_hds), .vcount_ds_out(s_vds), .tap_out(s_tap),
        .valid_ds_out(s_valid), .col_last_out(s_cl), .row_last_out(s_rl),
        .frame_done_out(s_done), .overrun_out(s_ovr), .busy_out(s_busy),
        .overrun_count_out(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int eh, input int ev, input int et,
                        input int ecl, input int erl);
        check({tag, ".valid"}, 32'(vds_v), 1);
        check({tag, ".h"}, 32'(hds), eh);
        check({tag, ".v"}, 32'(vds), ev);
        check({tag, ".tap"}, 32'(tap), et);
        check({tag, ".col_last"}, 32'(cl), ecl);
        check({tag, ".row_last"}, 32'(rl), erl);
    endtask

    int SH [24] = '{0,0,0,1,1,1,2,2,2,3,3,3, 0,0,0,1,1,1,2,2,2,3,3,3};
    int SV [24] = '{0,1,2,0,1,2,0,1,2,0,1,2, 3,4,5,3,4,5,3,4,5,3,4,5};

    initial begin
        int exp_cnt;
`ifdef DS_SCAN_OVERRUN_CNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        rst = 1'b1; h = 11'd1000; v = 10'd700; rdy = 1'b1;
        s_h = 11'd100; s_v = 10'd15; s_rdy = 1'b1;
        step(); step();
        check("rst.valid", 32'(vds_v), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.h", 32'(hds), 0);
        check("rst.v", 32'(vds), 0);
        check("rst.tap", 32'(tap), 0);
        check("rst.done", 32'(done), 0);
        check("rst.ovr", 32'(ovr), 0);
        check("rst.cnt", 32'(cnt), 0);
        rst = 1'b0;

        // Draw pass-through and window edges of valid_draw_out.
        h = 11'd100; v = 10'd50;
        step();
        check("draw.h", 32'(hds), 100);
        check("draw.v", 32'(vds), 50);
        check("draw.valid", 32'(vds_v), 0);
        check("draw.tap", 32'(tap), 0);
        check("draw.vd", 32'(vd), 1);
        h = 11'd240; v = 10'd0;   #1; check("vd.h240", 32'(vd), 0);
        h = 11'd239; v = 10'd319; #1; check("vd.corner", 32'(vd), 1);
        h = 11'd239; v = 10'd320; #1; check("vd.v320", 32'(vd), 0);
        h = 11'd1000; v = 10'd700;
        step();

        // Full scan at full throughput, with a stray trigger while busy.
        h = 11'd0; v = 10'd701;
        step();
        h = 11'd1000; v = 10'd700;
        for (int i = 0; i < 76800; i++) begin
            case (i)
                0:     begin beat("b0", 0, 0, 0, 0, 0); check("b0.busy", 32'(busy), 1); end
                1:     beat("b1", 0, 1, 1, 0, 0);
                2:     beat("b2", 0, 2, 2, 0, 0);
                3:     beat("b3", 0, 3, 3, 0, 0);
                4:     beat("b4", 0, 4, 4, 1, 0);
                5:     beat("b5", 1, 0, 0, 0, 0);
                300:   begin h = 11'd0; v = 10'd701; end
                301:   begin beat("b301", 60, 1, 1, 0, 0); h = 11'd1000; v = 10'd700; end
                1199:  beat("b1199", 239, 4, 4, 1, 1);
                1200:  beat("b1200", 0, 5, 0, 0, 0);
                76799: beat("b76799", 239, 319, 4, 1, 1);
                default: ;
            endcase
            step();
        end
        check("end.valid", 32'(vds_v), 0);
        check("end.busy", 32'(busy), 0);
        check("end.done", 32'(done), 1);
        check("end.ovr", 32'(ovr), 0);
        step();
        check("end.done_pulse", 32'(done), 0);

        // Backpressure on beat 7.
        h = 11'd0; v = 10'd701;
        step();
        h = 11'd1000; v = 10'd700;
        repeat (7) step();
        beat("bp.b7", 1, 2, 2, 0, 0);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            beat("bp.hold", 1, 2, 2, 0, 0);
        end
        rdy = 1'b1;
        step();
        beat("bp.b8", 1, 3, 3, 0, 0);

        // Stall through blanking until the raster wraps to (0,0).
        rdy = 1'b0;
        repeat (20) step();
        beat("ovr.hold", 1, 3, 3, 0, 0);
        h = 11'd0; v = 10'd0;
        step();
        h = 11'd1000; v = 10'd700;
        check("ovr.valid", 32'(vds_v), 0);
        check("ovr.busy", 32'(busy), 0);
        check("ovr.pulse", 32'(ovr), 1);
        check("ovr.done", 32'(done), 0);
        check("ovr.cnt", 32'(cnt), 32'(exp_cnt));
        step();
        check("ovr.pulse_end", 32'(ovr), 0);
        check("ovr.idle_valid", 32'(vds_v), 0);

        // Reset in the middle of a scan, then re-trigger.
        rdy = 1'b1;
        h = 11'd0; v = 10'd701;
        step();
        h = 11'd1000; v = 10'd700;
        repeat (500) step();
        beat("rs.b500", 100, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rs.valid", 32'(vds_v), 0);
        check("rs.busy", 32'(busy), 0);
        check("rs.h", 32'(hds), 0);
        check("rs.v", 32'(vds), 0);
        check("rs.tap", 32'(tap), 0);
        check("rs.cnt", 32'(cnt), 0);
        h = 11'd0; v = 10'd701;
        step();
        h = 11'd1000; v = 10'd700;
        beat("rs.retrig", 0, 0, 0, 0, 0);

        // Small configuration: complete 24-beat order.
        s_h = 11'd0; s_v = 10'd10;
        step();
        s_h = 11'd100; s_v = 10'd15;
        for (int i = 0; i < 24; i++) begin
            check($sformatf("sm%0d.valid", i), 32'(s_valid), 1);
            check($sformatf("sm%0d.h", i), 32'(s_hds), 32'(SH[i]));
            check($sformatf("sm%0d.v", i), 32'(s_vds), 32'(SV[i]));
            check($sformatf("sm%0d.tap", i), 32'(s_tap), 32'(SV[i] % 3));
            check($sformatf("sm%0d.row_last", i), 32'(s_rl), (i == 11 || i == 23) ? 1 : 0);
            step();
        end
        check("sm.end_valid", 32'(s_valid), 0);
        check("sm.done", 32'(s_done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
